// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one unsigned P x K multiplier among N requesters.
// Define MULT_SEQ_EN to replace the single-cycle multiply with a K-cycle shift-add sequence.
module mult_share_ctrl #(
    parameter int P    = 8,
    parameter int K    = 8,
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*P-1:0]    a_in,
    input  logic [N*K-1:0]    b_in,
    output logic [N-1:0]      gnt,
    output logic              busy,
    output logic              done,
    output logic [ID_W-1:0]   done_id,
    output logic [P+K-1:0]    result
);
    localparam int RW = P + K;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nx;
    logic [ID_W-1:0]   ptr, ptr_nx, win, id_cap;
    logic [P-1:0]      a_cap, a_sel;
    logic [K-1:0]      b_cap, b_sel;
    logic [2*N-1:0]    rr;
    logic              any_req, grant_en, calc_end;
    logic [RW-1:0]     prod;
    int                tmp;

    assign any_req  = |req;
    assign grant_en = ((state == IDLE) || (state == DONE)) && any_req;
    assign busy     = (state != IDLE);

`ifdef MULT_SEQ_EN
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    logic [CW-1:0] cnt;
    logic [RW-1:0] acc, term;

    assign term     = b_cap[cnt] ? (RW'(a_cap) << cnt) : '0;
    assign prod     = acc + term;
    assign calc_end = (state == CALC) && (cnt == CW'(K - 1));
`else
    assign prod     = RW'(a_cap) * RW'(b_cap);
    assign calc_end = (state == CALC);
`endif

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        rr   = {req, req} >> ptr;
        win  = '0;
        tmp  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rr[i]) begin
                tmp = int'(ptr) + i;
                if (tmp >= N) tmp = tmp - N;
                win = ID_W'(tmp);
            end
        end
        ptr_nx = (int'(win) == N - 1) ? '0 : win + 1'b1;
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (win == ID_W'(i)) begin
                a_sel = a_in[i*P +: P];
                b_sel = b_in[i*K +: K];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = CALC;
            CALC:    if (calc_end) state_nx = DONE;
            DONE:    state_nx = any_req ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            result  <= '0;
            ptr     <= '0;
            a_cap   <= '0;
            b_cap   <= '0;
            id_cap  <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            if (grant_en) begin
                gnt    <= N'(1) << win;
                a_cap  <= a_sel;
                b_cap  <= b_sel;
                id_cap <= win;
                ptr    <= ptr_nx;
            end
            if (calc_end) begin
                result  <= prod;
                done    <= 1'b1;
                done_id <= id_cap;
            end
        end
    end

`ifdef MULT_SEQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (grant_en) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == CALC) begin
            acc <= prod;
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed self-checking bench for mult_share_ctrl (default or MULT_SEQ_EN build).
module tb_mult_share_ctrl;
    localparam int P = 8, K = 8, N = 4, ID_W = 2;
`ifdef MULT_SEQ_EN
    localparam int LAT = K;
    localparam int RST_DLY = 3;
`else
    localparam int LAT = 1;
    localparam int RST_DLY = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*P-1:0]  a_in;
    logic [N*K-1:0]  b_in;
    logic [N-1:0]    gnt;
    logic            busy, done;
    logic [ID_W-1:0] done_id;
    logic [P+K-1:0]  result;

    int checks = 0;
    int failures = 0;

    mult_share_ctrl #(.P(P), .K(K), .N(N), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          w;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_lane(input int w, input logic [7:0] a, input logic [7:0] b);
        a_in[w*P +: P] = a;
        b_in[w*K +: K] = b;
    endtask

    task automatic wait_done(input int id, input logic [15:0] res);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 40);
        chk("latency", c, LAT);
        chk("done", {31'b0, done}, 1);
        chk("done_id", {30'b0, done_id}, id);
        chk("result", {16'b0, result}, {16'b0, res});
    endtask

    task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] res, input bit change_a);
        logic [15:0] held;
        for (int i = 0; i < N; i++) set_lane(i, 8'h77, 8'h77);
        set_lane(w, a, b);
        req = 4'b0001 << w;
        @(negedge clk);
        chk("op_gnt", {28'b0, gnt}, 32'b1 << w);
        chk("op_busy", {31'b0, busy}, 1);
        chk("op_done_early", {31'b0, done}, 0);
        req = '0;
        if (change_a) set_lane(w, 8'd99, b);
        wait_done(w, res);
        held = result;
        @(negedge clk);
        chk("op_done_drop", {31'b0, done}, 0);
        chk("op_busy_idle", {31'b0, busy}, 0);
        chk("op_result_hold", {16'b0, result}, {16'b0, held});
    endtask

    initial begin
        vt[0] = '{w: 2, a: 8'd13,  b: 8'd11,  res: 16'd143};
        vt[1] = '{w: 0, a: 8'hFF,  b: 8'hFF,  res: 16'hFE01};
        vt[2] = '{w: 0, a: 8'h00,  b: 8'hA5,  res: 16'h0000};
        vt[3] = '{w: 1, a: 8'd200, b: 8'd3,   res: 16'd600};
        vt[4] = '{w: 3, a: 8'hFF,  b: 8'd1,   res: 16'h00FF};
        vt[5] = '{w: 3, a: 8'hA5,  b: 8'h00,  res: 16'h0000};

        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", {28'b0, gnt}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_done_id", {30'b0, done_id}, 0);
        chk("rst_result", {16'b0, result}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) do_op(vt[i].w, vt[i].a, vt[i].b, vt[i].res, 1'b0);

        // fairness: all four continuously requesting, pointer starts at 0 after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_lane(i, 8'(i + 1), 8'd10);
        req = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("rr_gnt", {28'b0, gnt}, 32'b1 << (k % 4));
            if (k == 4) req = '0;
            wait_done(k % 4, 16'((k % 4 + 1) * 10));
            @(negedge clk);
        end
        chk("rr_idle", {31'b0, busy}, 0);

        // pointer wrap: grant to 3 first, then 0 before 3
        do_op(3, 8'd4, 8'd4, 16'd16, 1'b0);
        set_lane(0, 8'd2, 8'd7);
        set_lane(3, 8'd3, 8'd9);
        req = 4'b1001;
        @(negedge clk);
        chk("wrap_gnt0", {28'b0, gnt}, 32'b0001);
        req = 4'b1000;
        wait_done(0, 16'd14);
        @(negedge clk);
        chk("wrap_gnt3", {28'b0, gnt}, 32'b1000);
        req = '0;
        wait_done(3, 16'd27);
        @(negedge clk);

        // operands captured only at grant
        do_op(0, 8'd5, 8'd3, 16'd15, 1'b1);

        // reset while the operation is in flight
        set_lane(1, 8'd6, 8'd7);
        req = 4'b0010;
        @(negedge clk);
        chk("abort_gnt", {28'b0, gnt}, 32'b0010);
        req = '0;
        repeat (RST_DLY) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", {31'b0, done}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_result", {16'b0, result}, 0);
        chk("abort_gnt_clr", {28'b0, gnt}, 0);
        for (int i = 0; i < N; i++) set_lane(i, 8'(i + 2), 8'd5);
        req = 4'b1111;
        @(negedge clk);
        chk("abort_ptr0", {28'b0, gnt}, 32'b0001);
        req = '0;
        wait_done(0, 16'd10);
        @(negedge clk);
        chk("abort_no_done", {31'b0, done}, 0);
        do_op(1, 8'd13, 8'd11, 16'd143, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
